// File: rtl/automat_multi_if.sv
// -----------------------------------------------------------------------------
// automat_multi_if
// Bundles the customer-side signals of the vending automat into one interface.
//   master modport : drives coins / select / buy (and cancel), observes outputs
//   slave modport  : the automat itself
// Signals:
//   b1, b5, b10    coin inserted this cycle (1 / 5 / 10 units)
//   sel            product select, 0 = A, 1 = B
//   buy            purchase request
//   cancel         refund request (only when AUTOMAT_CANCEL_EN is defined)
//   vend_a, vend_b product dispensed, one-cycle pulse
//   r1, r5         change coin returned, one-cycle pulse
//   reject         coin refused, one-cycle pulse
//   credit         current credit, CREDIT_W bits
// Optional feature macro: AUTOMAT_CANCEL_EN
// -----------------------------------------------------------------------------
interface automat_multi_if #(
  parameter int CREDIT_W = 5
);
  logic                b1;
  logic                b5;
  logic                b10;
  logic                sel;
  logic                buy;
`ifdef AUTOMAT_CANCEL_EN
  logic                cancel;
`endif
  logic                vend_a;
  logic                vend_b;
  logic                r1;
  logic                r5;
  logic                reject;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output b1, b5, b10, sel, buy,
`ifdef AUTOMAT_CANCEL_EN
    output cancel,
`endif
    input  vend_a, vend_b, r1, r5, reject, credit
  );

  modport slave (
    input  b1, b5, b10, sel, buy,
`ifdef AUTOMAT_CANCEL_EN
    input  cancel,
`endif
    output vend_a, vend_b, r1, r5, reject, credit
  );
endinterface

// File: rtl/automat_multi.sv
// -----------------------------------------------------------------------------
// automat_multi
// Two-product vending automat. Accepts 1/5/10 coins while idle, vends product
// A or B when credit covers the price, then pays the remainder back as a run
// of r5 / r1 pulses (one per cycle). All outputs are registered.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    automat_multi_if.slave (coins, select, buy, pulses, credit)
// Parameters: PRICE_A, PRICE_B, MAX_CREDIT, CREDIT_W
//   (1 <= PRICE_A, PRICE_B <= MAX_CREDIT < 2**CREDIT_W)
// Optional feature macro: AUTOMAT_CANCEL_EN adds bus.cancel, which refunds the
// whole credit as change without vending.
// -----------------------------------------------------------------------------
module automat_multi #(
  parameter int PRICE_A    = 7,
  parameter int PRICE_B    = 12,
  parameter int MAX_CREDIT = 20,
  parameter int CREDIT_W   = 5
) (
  input  logic           clk,
  input  logic           reset,
  automat_multi_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_A_C = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PRICE_B_C = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W-1:0] ONE_C     = CREDIT_W'(32'd1);
  localparam logic [CREDIT_W-1:0] FIVE_C    = CREDIT_W'(32'd5);
  localparam logic [CREDIT_W-1:0] ZERO_C    = CREDIT_W'(32'd0);
  // One extra bit so credit + coin cannot wrap before the limit check.
  localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state_q,  state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_a_q, vend_a_d;
  logic                vend_b_q, vend_b_d;
  logic                r1_q,     r1_d;
  logic                r5_q,     r5_d;
  logic                reject_q, reject_d;

  logic [1:0]          coin_cnt_s;
  logic [CREDIT_W:0]   coin_val_s;
  logic [CREDIT_W:0]   credit_sum_s;
  logic                coin_any_s;
  logic                coin_ok_s;
  logic [CREDIT_W-1:0] price_s;
  logic                chg_r5_s;
  logic [CREDIT_W-1:0] chg_credit_s;
  logic                cancel_req_s;

  // Coin decode, price select and the next change step
  always_comb begin
    coin_cnt_s = {1'b0, bus.b1} + {1'b0, bus.b5} + {1'b0, bus.b10};
    case ({bus.b10, bus.b5, bus.b1})
      3'b001:  coin_val_s = (CREDIT_W+1)'(32'd1);
      3'b010:  coin_val_s = (CREDIT_W+1)'(32'd5);
      3'b100:  coin_val_s = (CREDIT_W+1)'(32'd10);
      default: coin_val_s = (CREDIT_W+1)'(32'd0);
    endcase
    coin_any_s   = (coin_cnt_s != 2'd0);
    credit_sum_s = {1'b0, credit_q} + coin_val_s;
    coin_ok_s    = (coin_cnt_s == 2'd1) && (credit_sum_s <= MAX_C);
    price_s      = bus.sel ? PRICE_B_C : PRICE_A_C;
    // Change is paid largest coin first: r5 while at least 5 remains.
    if (credit_q >= FIVE_C) begin
      chg_r5_s     = 1'b1;
      chg_credit_s = credit_q - FIVE_C;
    end else begin
      chg_r5_s     = 1'b0;
      chg_credit_s = credit_q - ONE_C;
    end
`ifdef AUTOMAT_CANCEL_EN
    cancel_req_s = bus.cancel;
`else
    cancel_req_s = 1'b0;
`endif
  end

  // FSM next state, next credit and next output pulses
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    vend_a_d = 1'b0;
    vend_b_d = 1'b0;
    r1_d     = 1'b0;
    r5_d     = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coin_any_s) begin
          // A coin always wins over buy / cancel in the same cycle.
          if (coin_ok_s) begin
            credit_d = credit_sum_s[CREDIT_W-1:0];
          end else begin
            reject_d = 1'b1;
          end
        end else if (bus.buy) begin
          if (credit_q >= price_s) begin
            state_d  = ST_VEND;
            credit_d = credit_q - price_s;
            vend_a_d = ~bus.sel;
            vend_b_d = bus.sel;
          end else begin
            credit_d = credit_q;
          end
        end else if (cancel_req_s && (credit_q != ZERO_C)) begin
          // Refund starts immediately: the first change pulse comes with CHANGE.
          state_d  = ST_CHANGE;
          credit_d = chg_credit_s;
          r5_d     = chg_r5_s;
          r1_d     = ~chg_r5_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND, ST_CHANGE: begin
        // Coins are refused while a vend or payout is in progress.
        reject_d = coin_any_s;
        if (credit_q != ZERO_C) begin
          state_d  = ST_CHANGE;
          credit_d = chg_credit_s;
          r5_d     = chg_r5_s;
          r1_d     = ~chg_r5_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = ZERO_C;
      end
    endcase
  end

  // State, credit and registered output pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      credit_q <= ZERO_C;
      vend_a_q <= 1'b0;
      vend_b_q <= 1'b0;
      r1_q     <= 1'b0;
      r5_q     <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_a_q <= vend_a_d;
      vend_b_q <= vend_b_d;
      r1_q     <= r1_d;
      r5_q     <= r5_d;
      reject_q <= reject_d;
    end
  end

  assign bus.vend_a = vend_a_q;
  assign bus.vend_b = vend_b_q;
  assign bus.r1     = r1_q;
  assign bus.r5     = r5_q;
  assign bus.reject = reject_q;
  assign bus.credit = credit_q;

endmodule

// File: tb/tb_automat_multi.sv
// -----------------------------------------------------------------------------
// tb_automat_multi
// Directed vectors with hand-computed expected pulses and credit. Each driven
// cycle pushes its expected next-cycle outputs into a queue; a monitor on the
// falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_automat_multi;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   nvec = 0;
  int   vectors = 0;
  int   miscompares = 0;
  event chk_ev;

  typedef struct {
    int         due;
    int         id;
    logic [4:0] o;   // {vend_a, vend_b, r1, r5, reject}
    logic [4:0] cr;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  automat_multi_if #(.CREDIT_W(5)) bus ();

  automat_multi #(
    .PRICE_A   (7),
    .PRICE_B   (12),
    .MAX_CREDIT(20),
    .CREDIT_W  (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic push_exp(input int due, input logic [4:0] o, input logic [4:0] cr);
    exp_t e;
    e.due = due;
    e.id  = nvec;
    e.o   = o;
    e.cr  = cr;
    nvec++;
    q.push_back(e);
  endtask

  // c = {b10, b5, b1}; o = expected {vend_a, vend_b, r1, r5, reject} next cycle
  task automatic step(input logic r, input logic [2:0] c, input logic s, input logic by,
                      input logic [4:0] o, input logic [4:0] cr);
    reset   = r;
    bus.b10 = c[2];
    bus.b5  = c[1];
    bus.b1  = c[0];
    bus.sel = s;
    bus.buy = by;
    push_exp(cyc + 1, o, cr);
    @(posedge clk);
    #1;
  endtask

  // Pull reset low between clock edges and check outputs clear with no edge.
  task automatic async_reset_check();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    push_exp(cyc, 5'b00000, 5'd0);
    -> chk_ev;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation that has come due
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        vectors++;
        if ({bus.vend_a, bus.vend_b, bus.r1, bus.r5, bus.reject} !== e.o || bus.credit !== e.cr) begin
          miscompares++;
          $display("FAIL vec%0d: got pulses(va,vb,r1,r5,rej)=%b credit=%0d, want pulses=%b credit=%0d",
                   e.id, {bus.vend_a, bus.vend_b, bus.r1, bus.r5, bus.reject}, bus.credit, e.o, e.cr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    bus.b1  = 1'b0;
    bus.b5  = 1'b0;
    bus.b10 = 1'b0;
    bus.sel = 1'b0;
    bus.buy = 1'b0;
`ifdef AUTOMAT_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    push_exp(1, 5'b00000, 5'd0);
    @(posedge clk);
    #1;
    step(1'b0, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd0);

    // b10, b5, buy A: vend then r5 once and r1 three times
    step(1'b1, 3'b100, 1'b0, 1'b0, 5'b00000, 5'd10);
    step(1'b1, 3'b010, 1'b0, 1'b0, 5'b00000, 5'd15);
    step(1'b1, 3'b000, 1'b0, 1'b1, 5'b10000, 5'd8);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00010, 5'd3);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00100, 5'd2);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00100, 5'd1);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00100, 5'd0);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd0);

    // Fill to the limit; a further b5 and b1 are refused
    step(1'b1, 3'b100, 1'b0, 1'b0, 5'b00000, 5'd10);
    step(1'b1, 3'b100, 1'b0, 1'b0, 5'b00000, 5'd20);
    step(1'b1, 3'b010, 1'b0, 1'b0, 5'b00001, 5'd20);
    step(1'b1, 3'b001, 1'b0, 1'b0, 5'b00001, 5'd20);
    // Buy B from 20; coins during VEND and CHANGE are refused
    step(1'b1, 3'b000, 1'b1, 1'b1, 5'b01000, 5'd8);
    step(1'b1, 3'b001, 1'b0, 1'b0, 5'b00011, 5'd3);
    step(1'b1, 3'b010, 1'b0, 1'b0, 5'b00101, 5'd2);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00100, 5'd1);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00100, 5'd0);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd0);

    // Insufficient credit, double coin, coin with buy
    step(1'b1, 3'b001, 1'b0, 1'b0, 5'b00000, 5'd1);
    step(1'b1, 3'b001, 1'b0, 1'b0, 5'b00000, 5'd2);
    step(1'b1, 3'b001, 1'b0, 1'b0, 5'b00000, 5'd3);
    step(1'b1, 3'b000, 1'b1, 1'b1, 5'b00000, 5'd3);
    step(1'b1, 3'b000, 1'b0, 1'b1, 5'b00000, 5'd3);
    step(1'b1, 3'b011, 1'b0, 1'b0, 5'b00001, 5'd3);
    step(1'b1, 3'b010, 1'b0, 1'b1, 5'b00000, 5'd8);
    step(1'b1, 3'b000, 1'b0, 1'b1, 5'b10000, 5'd1);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00100, 5'd0);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd0);

    // Exact price: VEND with zero remainder goes straight back to IDLE
    step(1'b1, 3'b010, 1'b0, 1'b0, 5'b00000, 5'd5);
    step(1'b1, 3'b001, 1'b0, 1'b0, 5'b00000, 5'd6);
    step(1'b1, 3'b001, 1'b0, 1'b0, 5'b00000, 5'd7);
    step(1'b1, 3'b000, 1'b0, 1'b1, 5'b10000, 5'd0);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd0);
    step(1'b1, 3'b001, 1'b0, 1'b0, 5'b00000, 5'd1);

    // Reset in the middle of CHANGE; payout is not resumed
    step(1'b1, 3'b100, 1'b0, 1'b0, 5'b00000, 5'd11);
    step(1'b1, 3'b000, 1'b0, 1'b1, 5'b10000, 5'd4);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00100, 5'd3);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00100, 5'd2);
    async_reset_check();
    step(1'b0, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd0);
    step(1'b1, 3'b001, 1'b0, 1'b0, 5'b00000, 5'd1);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd1);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd1);

`ifdef AUTOMAT_CANCEL_EN
    // Cancel refunds 6 as r5 then r1; cancel at zero credit does nothing
    step(1'b1, 3'b010, 1'b0, 1'b0, 5'b00000, 5'd6);
    bus.cancel = 1'b1;
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00010, 5'd1);
    bus.cancel = 1'b0;
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00100, 5'd0);
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd0);
    bus.cancel = 1'b1;
    step(1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 5'd0);
    bus.cancel = 1'b0;
`endif

    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
